// File: rtl/conv_scheduler.sv
// Round-robin scheduler sharing one fixed-latency power converter among NUM_CH sources.
// Optional EMIT stall timeout with drop counter is enabled by defining SCHED_TIMEOUT_EN.
module conv_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int DW       = 8,
  parameter int CONV_LAT = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH*DW-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_ack,
  output logic [DW-1:0]        conv_in,
  input  logic [DW-1:0]        conv_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [2:0]           out_ch,
  output logic                 busy,
  output logic [15:0]          sample_cnt,
  output logic [7:0]           drop_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;
  localparam int PAD_W = 8 * DW;

  logic [1:0]        state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        last_ch_q, last_ch_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic [DW-1:0]     conv_in_q, conv_in_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [2:0]        out_ch_q, out_ch_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;

  logic [7:0]        req_pad_s;
  logic [7:0]        onehot_s;
  logic [PAD_W-1:0]  data_pad_s;
  logic [2:0]        winner_s, cand_s;
  logic              found_s;
  logic              timeout_hit_s;

  // Padding to eight lanes lets a 3-bit channel index address requests and samples directly.
  assign req_pad_s  = 8'(ch_req);
  assign data_pad_s = PAD_W'(ch_data);
  assign onehot_s   = 8'd1 << winner_s;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_ch_q;
    cand_s   = last_ch_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_s = 3'((int'(last_ch_q) + i) % NUM_CH);
      if (!found_s && req_pad_s[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign timeout_hit_s = (state_q == EMIT) && !out_ready && (stall_q == 8'(TIMEOUT - 1));
  assign drop_cnt      = drop_cnt_q;

  // Stall counter is held at zero outside EMIT so it starts clean on every entry.
  always_comb begin
    stall_d    = stall_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q != EMIT) begin
      stall_d = 8'd0;
    end else if (timeout_hit_s) begin
      stall_d    = 8'd0;
      drop_cnt_d = (drop_cnt_q == 8'd255) ? drop_cnt_q : drop_cnt_q + 8'd1;
    end else if (!out_ready) begin
      stall_d = stall_q + 8'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall and drop registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q    <= 8'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      stall_q    <= stall_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign drop_cnt      = 8'd0;
`endif

  // Scheduler FSM next-state and datapath.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_ch_d    = last_ch_q;
    wait_cnt_d   = wait_cnt_q;
    ch_ack_d     = '0;
    conv_in_d    = conv_in_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable && found_s) begin
          state_d    = LOAD;
          sel_d      = winner_s;
          conv_in_d  = data_pad_s[winner_s * DW +: DW];
          ch_ack_d   = onehot_s[NUM_CH-1:0];
          wait_cnt_d = 4'(CONV_LAT - 1);
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          out_data_d  = conv_out;
          out_ch_d    = sel_q;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d  = 1'b0;
          last_ch_d    = sel_q;
          sample_cnt_d = sample_cnt_q + 16'd1;
          state_d      = IDLE;
        end else if (timeout_hit_s) begin
          out_valid_d = 1'b0;
          last_ch_d   = sel_q;
          state_d     = IDLE;
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 3'd0;
      last_ch_q    <= 3'(NUM_CH - 1);
      wait_cnt_q   <= 4'd0;
      ch_ack_q     <= '0;
      conv_in_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= 3'd0;
      sample_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_ch_q    <= last_ch_d;
      wait_cnt_q   <= wait_cnt_d;
      ch_ack_q     <= ch_ack_d;
      conv_in_q    <= conv_in_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign ch_ack     = ch_ack_q;
  assign conv_in    = conv_in_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign busy       = (state_q != IDLE);
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler; converter modelled as a 2-stage pipeline adding 0x11.
module tb_conv_scheduler;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
`ifdef SCHED_TIMEOUT_EN
  localparam int TMO   = 10;
  localparam int STALL = 7;
`else
  localparam int TMO   = 255;
  localparam int STALL = 20;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [3:0]        ch_req;
  logic [31:0]       ch_data;
  logic [3:0]        ch_ack;
  logic [7:0]        conv_in;
  logic [7:0]        conv_out;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [2:0]        out_ch;
  logic              busy;
  logic [15:0]       sample_cnt;
  logic [7:0]        drop_cnt;
  logic [7:0]        pipe1, pipe2;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_ack;
    logic [2:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_cnt = 0;

  conv_scheduler #(.NUM_CH(NUM_CH), .DW(DW), .CONV_LAT(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_req(ch_req), .ch_data(ch_data),
    .ch_ack(ch_ack), .conv_in(conv_in), .conv_out(conv_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .busy(busy),
    .sample_cnt(sample_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    pipe1 <= conv_in + 8'h11;
    pipe2 <= pipe1;
  end
  assign conv_out = pipe2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ack(input string name);
    logic seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ch_ack != 4'd0) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) check({name, "_ack_pulse"}, 32'(ch_ack), 32'd0);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // One full sample: request, grant, converter latency, handshake.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    ch_req = v.req;
    wait_ack(name);
    check({name, "_ack"}, 32'(ch_ack), 32'(v.exp_ack));
    ch_req = 4'd0;
    wait_valid(name, lat);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_data"}, 32'(out_data), 32'(v.exp_data));
    check({name, "_ch"}, 32'(out_ch), 32'(v.exp_ch));
    @(negedge clk);
    exp_cnt++;
    check({name, "_cnt"}, 32'(sample_cnt), 32'(exp_cnt));
    check({name, "_valid_low"}, 32'(out_valid), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_ack;
    int last_t;
    int vcnt;
    vec_t v;
    logic [3:0] exp_oh;

    vecs[0] = '{4'b1111, 4'b0001, 3'd0, 8'hB1};
    vecs[1] = '{4'b0100, 4'b0100, 3'd2, 8'h6B};
    vecs[2] = '{4'b0111, 4'b0001, 3'd0, 8'hB1};
    vecs[3] = '{4'b0110, 4'b0010, 3'd1, 8'h4D};
    vecs[4] = '{4'b1001, 4'b1000, 3'd3, 8'hD4};
    vecs[5] = '{4'b1001, 4'b0001, 3'd0, 8'hB1};
    vecs[6] = '{4'b0010, 4'b0010, 3'd1, 8'h4D};
    vecs[7] = '{4'b1000, 4'b1000, 3'd3, 8'hD4};

    rst       = 1'b1;
    enable    = 1'b1;
    ch_req    = 4'b1111;
    ch_data   = {8'hC3, 8'h5A, 8'h3C, 8'hA0};
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ch_ack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(sample_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_conv_in", 32'(conv_in), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Held requests: grants rotate 0,1,2,3,0 every five cycles.
    ch_req = 4'b1111;
    n_ack  = 0;
    last_t = 0;
    for (int t = 0; t < 60 && n_ack < 5; t++) begin
      @(negedge clk);
      if (ch_ack != 4'd0) begin
        exp_oh = 4'b0001 << (n_ack % 4);
        check($sformatf("rr_ack%0d", n_ack), 32'(ch_ack), 32'(exp_oh));
        if (n_ack > 0) check($sformatf("rr_gap%0d", n_ack), 32'(t - last_t), 32'd5);
        last_t = t;
        n_ack++;
      end
    end
    check("rr_count", 32'(n_ack), 32'd5);
    ch_req = 4'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    exp_cnt += 5;
    check("rr_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Backpressure while other channels keep requesting.
    out_ready = 1'b0;
    ch_req    = 4'b0100;
    wait_ack("bp");
    check("bp_ack", 32'(ch_ack), 32'b0100);
    ch_req = 4'b1111;
    wait_valid("bp", lat);
    check("bp_latency", 32'(lat), 32'd3);
    for (int k = 0; k < STALL; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_data%0d", k), 32'(out_data), 32'h6B);
      check($sformatf("bp_ch%0d", k), 32'(out_ch), 32'd2);
      check($sformatf("bp_noack%0d", k), 32'(ch_ack), 32'd0);
    end
    ch_req    = 4'd0;
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("bp_valid_low", 32'(out_valid), 32'd0);
    check("bp_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Enable dropped during WAIT: sample still completes, no further grants.
    ch_req = 4'b0001;
    wait_ack("en");
    check("en_ack", 32'(ch_ack), 32'b0001);
    enable = 1'b0;
    ch_req = 4'b1111;
    wait_valid("en", lat);
    check("en_latency", 32'(lat), 32'd3);
    check("en_data", 32'(out_data), 32'hB1);
    @(negedge clk);
    exp_cnt++;
    check("en_cnt", 32'(sample_cnt), 32'(exp_cnt));
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || ch_ack != 4'd0) vcnt++;
    end
    check("en_quiet", 32'(vcnt), 32'd0);

    // Reset during WAIT aborts the sample.
    enable = 1'b1;
    wait_ack("rmid");
    check("rmid_ack", 32'(ch_ack), 32'b0010);
    @(negedge clk);
    rst    = 1'b1;
    ch_req = 4'd0;
    @(negedge clk);
    rst  = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("rmid_no_valid", 32'(vcnt), 32'd0);
    check("rmid_cnt", 32'(sample_cnt), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    exp_cnt = 0;
    v = '{4'b1010, 4'b0010, 3'd1, 8'h4D};
    run_vec(v, "post_rst0");
    v = '{4'b1010, 4'b1000, 3'd3, 8'hD4};
    run_vec(v, "post_rst1");

`ifdef SCHED_TIMEOUT_EN
    // Stall timeout: out_valid held for TMO cycles, then dropped and next channel served.
    out_ready = 1'b0;
    ch_req    = 4'b1111;
    wait_ack("to");
    check("to_ack", 32'(ch_ack), 32'b0001);
    wait_valid("to", lat);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!out_valid) break;
      vcnt++;
      @(negedge clk);
    end
    check("to_valid_cycles", 32'(vcnt), 32'(TMO));
    check("to_drop1", 32'(drop_cnt), 32'd1);
    wait_ack("to_next");
    check("to_next_ack", 32'(ch_ack), 32'b0010);
    repeat (4500) @(negedge clk);
    check("to_drop_sat", 32'(drop_cnt), 32'd255);
    check("to_cnt_same", 32'(sample_cnt), 32'(exp_cnt));
    ch_req = 4'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
